basys3_link_tx: RTL and testbench

- Basys3-side serial transmitter for the PMOD link; the sending end of the frame that the Cmod A7 receive path deserialises into data, key and mode.
- Latches one 128-bit data word, one 128-bit key and a mode bit, then shifts the resulting 257-bit frame out one bit per four-phase sync/acknowledge handshake.
- The handshake makes the link independent of the ratio between the 100 MHz Basys3 clock and the 12 MHz Cmod clock.

---
 rtl/basys3_link_tx.sv | 168 ++++++++++++++++
 tb/tb_basys3_link_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basys3_link_tx.sv
// Basys3-side PMOD link transmitter: shifts {encrypt, data, key} out one bit per
// four-phase tx_sync/rx_ack handshake. Optional watchdog: define LINK_TIMEOUT_EN.
module basys3_link_tx #(
    parameter int SETUP_CYCLES   = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         enable,
    input  logic [127:0] data_out,
    input  logic [127:0] key_in,
    input  logic         encrypt,
    output logic         txd,
    output logic         tx_sync,
    input  logic         rx_ack,
    output logic         busy,
    output logic         done
`ifdef LINK_TIMEOUT_EN
    ,
    output logic         error
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_REL, S_DONE} state_t;

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [8:0]    LAST_BIT   = 9'd256;

    if (SETUP_CYCLES < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("basys3_link_tx: parameter out of range");
    end

    state_t                 r_state;
    logic [256:0]           r_shift;
    logic [8:0]             r_cnt;
    logic [SW-1:0]          r_setup_cnt;
    logic                   r_txd;
    logic                   r_tx_sync;
    logic                   r_busy;
    logic                   r_done;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   w_timeout;
    logic                   w_locked;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], rx_ack};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

`ifdef LINK_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;
    logic        r_error;

    // Watchdog only advances while a handshake phase is stalled; any phase change clears it.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            if ((r_state == S_REQ && !w_ack_s) || (r_state == S_REL && w_ack_s)) begin
                r_wdog <= r_wdog + 16'd1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign w_timeout = (r_state == S_REQ || r_state == S_REL) && (r_wdog == WD_LAST);
    assign w_locked  = r_error;
    assign error     = r_error;
`else
    assign w_timeout = 1'b0;
    assign w_locked  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_setup_cnt <= '0;
            r_txd       <= 1'b0;
            r_tx_sync   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_timeout) begin
                r_state   <= S_DONE;
                r_tx_sync <= 1'b0;
                r_txd     <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A peer still holding ack from an earlier exchange must release first.
                        if (enable && !w_ack_s && !w_locked) begin
                            r_shift     <= {encrypt, data_out, key_in};
                            r_cnt       <= '0;
                            r_setup_cnt <= '0;
                            r_txd       <= encrypt;
                            r_busy      <= 1'b1;
                            r_state     <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        r_txd <= r_shift[256];
                        if (r_setup_cnt == SETUP_LAST) begin
                            r_tx_sync <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            r_setup_cnt <= r_setup_cnt + 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (w_ack_s) begin
                            r_tx_sync <= 1'b0;
                            r_state   <= S_REL;
                        end
                    end
                    S_REL: begin
                        if (!w_ack_s) begin
                            if (r_cnt == LAST_BIT) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_txd   <= 1'b0;
                            end else begin
                                r_shift     <= {r_shift[255:0], 1'b0};
                                r_cnt       <= r_cnt + 9'd1;
                                r_txd       <= r_shift[255];
                                r_setup_cnt <= '0;
                                r_state     <= S_SETUP;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign txd     = r_txd;
    assign tx_sync = r_tx_sync;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_basys3_link_tx.sv
// Directed bench for basys3_link_tx: handshaking peer model, frame capture on
// rising tx_sync, and per-scenario checks against hand-built expected frames.
module tb_basys3_link_tx;

`ifdef LINK_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic         clk = 1'b0;
    logic         reset_b = 1'b0;
    logic         enable = 1'b0;
    logic         encrypt = 1'b0;
    logic [127:0] data_out = '0;
    logic [127:0] key_in = '0;
    logic         rx_ack;
    logic         txd, tx_sync, busy, done;
`ifdef LINK_TIMEOUT_EN
    logic         error;
`endif

    int passed = 0;
    int total  = 0;

    bit hold_high = 1'b0;
    bit slow      = 1'b0;
    int fixed_dly = 3;
    int peer_stop = -1;
    int stop_base = 0;

    logic cap [0:4095];
    int   pulses = 0;
    int   dones  = 0;
    int   viol   = 0;
    logic prev_sync = 1'b0;
    logic prev_txd  = 1'b0;

    basys3_link_tx #(
        .SETUP_CYCLES  (4),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .enable  (enable),
        .data_out(data_out),
        .key_in  (key_in),
        .encrypt (encrypt),
        .txd     (txd),
        .tx_sync (tx_sync),
        .rx_ack  (rx_ack),
        .busy    (busy),
        .done    (done)
`ifdef LINK_TIMEOUT_EN
        ,
        .error   (error)
`endif
    );

    always #5 clk = ~clk;

    function automatic int dly();
        if (slow) return int'($urandom_range(50, 1));
        return fixed_dly;
    endfunction

    // Peer: four-phase acknowledge with configurable response delay per edge.
    initial begin
        rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_high) begin
                rx_ack = 1'b1;
            end else if (tx_sync && !rx_ack) begin
                repeat (dly()) @(negedge clk);
                if (!hold_high && tx_sync && (peer_stop < 0 || (pulses - stop_base) <= peer_stop))
                    rx_ack = 1'b1;
            end else if (!tx_sync && rx_ack) begin
                repeat (dly()) @(negedge clk);
                rx_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_sync && !prev_sync) begin
            cap[pulses] <= txd;
            pulses      <= pulses + 1;
        end
        if (done) dones <= dones + 1;
        if (reset_b && (txd != prev_txd) && (tx_sync || rx_ack)) viol <= viol + 1;
        prev_sync <= tx_sync;
        prev_txd  <= txd;
    end

    function automatic logic [256:0] get_frame(input int base);
        logic [256:0] f;
        for (int i = 0; i < 257; i++) f[256-i] = cap[base+i];
        return f;
    endfunction

    task automatic start_frame(input logic [127:0] d, input logic [127:0] k, input logic e,
                               output bit ok);
        data_out = d;
        key_in   = k;
        encrypt  = e;
        enable   = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        enable = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (txd !== 1'b0) $display("FAIL reset_txd got=%b exp=0", txd); else passed++;
        total++; if (tx_sync !== 1'b0) $display("FAIL reset_tx_sync got=%b exp=0", tx_sync); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [127:0] d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        logic [127:0] k = 128'h000102030405060708090A0B0C0D0E0F;
        logic [256:0] exp_f = {1'b1, d, k};
        int base = pulses;
        int dbase = dones;
        bit ok;
        fixed_dly = 3;
        start_frame(d, k, 1'b1, ok);
        total++; if (!ok) $display("FAIL basic_start busy=%b exp=1", busy); else passed++;
        wait_done(20000, ok);
        total++; if (!ok) $display("FAIL basic_done_timeout got=0 exp=1"); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", busy); else passed++;
        total++; if (txd !== 1'b0) $display("FAIL basic_txd_at_done got=%b exp=0", txd); else passed++;
        repeat (5) @(negedge clk);
        total++; if (pulses - base != 257) $display("FAIL basic_pulses got=%0d exp=257", pulses - base); else passed++;
        total++; if (get_frame(base) !== exp_f) $display("FAIL basic_frame got=%h exp=%h", get_frame(base), exp_f); else passed++;
        total++; if (dones - dbase != 1) $display("FAIL basic_done_count got=%0d exp=1", dones - dbase); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_decrypt();
        logic [256:0] g;
        int base = pulses;
        bit ok;
        fixed_dly = 3;
        start_frame({128{1'b1}}, 128'h0, 1'b0, ok);
        wait_done(20000, ok);
        total++; if (!ok) $display("FAIL dec_done_timeout got=0 exp=1"); else passed++;
        repeat (3) @(negedge clk);
        g = get_frame(base);
        total++; if (pulses - base != 257) $display("FAIL dec_pulses got=%0d exp=257", pulses - base); else passed++;
        total++; if (g[256] !== 1'b0) $display("FAIL dec_mode_bit got=%b exp=0", g[256]); else passed++;
        total++; if (g[255:128] !== {128{1'b1}}) $display("FAIL dec_data got=%h exp=all-ones", g[255:128]); else passed++;
        total++; if (g[127:0] !== 128'h0) $display("FAIL dec_key got=%h exp=0", g[127:0]); else passed++;
    endtask

    task automatic test_slow_peer();
        logic [127:0] d = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        logic [127:0] k = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        logic [256:0] exp_f = {1'b1, d, k};
        int base = pulses;
        int vbase = viol;
        bit ok;
        slow = 1'b1;
        start_frame(d, k, 1'b1, ok);
        wait_done(40000, ok);
        total++; if (!ok) $display("FAIL slow_done_timeout got=0 exp=1"); else passed++;
        repeat (3) @(negedge clk);
        slow = 1'b0;
        total++; if (pulses - base != 257) $display("FAIL slow_pulses got=%0d exp=257", pulses - base); else passed++;
        total++; if (get_frame(base) !== exp_f) $display("FAIL slow_frame got=%h exp=%h", get_frame(base), exp_f); else passed++;
        total++; if (viol - vbase != 0) $display("FAIL slow_txd_stable violations=%0d exp=0", viol - vbase); else passed++;
        repeat (120) @(negedge clk);
    endtask

    task automatic test_busy_peer();
        logic [127:0] d = 128'hCAFEBABE_00000000_FFFFFFFF_13572468;
        logic [127:0] k = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        logic [256:0] exp_f = {1'b0, d, k};
        int base;
        bit ok;
        fixed_dly = 1;
        hold_high = 1'b1;
        repeat (10) @(negedge clk);
        base     = pulses;
        data_out = d;
        key_in   = k;
        encrypt  = 1'b0;
        enable   = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL busy_peer_no_load busy=%b exp=0", busy); else passed++;
        total++; if (pulses - base != 0) $display("FAIL busy_peer_no_sync pulses=%0d exp=0", pulses - base); else passed++;
        hold_high = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        total++; if (!ok) $display("FAIL busy_peer_start busy=0 exp=1"); else passed++;
        wait_done(20000, ok);
        repeat (3) @(negedge clk);
        total++; if (get_frame(base) !== exp_f) $display("FAIL busy_peer_frame got=%h exp=%h", get_frame(base), exp_f); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        logic [127:0] k1 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
        logic [127:0] d2 = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
        logic [127:0] k2 = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
        int base = pulses;
        int dbase = dones;
        int n = 0;
        fixed_dly = 1;
        data_out = d1;
        key_in   = k1;
        encrypt  = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 30000 && n < 2; i++) begin
            @(negedge clk);
            if (done) begin
                n++;
                if (n == 1) begin
                    data_out = d2;
                    key_in   = k2;
                    encrypt  = 1'b0;
                end else begin
                    enable = 1'b0;
                end
            end
        end
        enable = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (n != 2) $display("FAIL b2b_frames got=%0d exp=2", n); else passed++;
        total++; if (pulses - base != 514) $display("FAIL b2b_pulses got=%0d exp=514", pulses - base); else passed++;
        total++; if (dones - dbase != 2) $display("FAIL b2b_done_count got=%0d exp=2", dones - dbase); else passed++;
        total++; if (get_frame(base) !== {1'b1, d1, k1}) $display("FAIL b2b_frame1 got=%h", get_frame(base)); else passed++;
        total++; if (get_frame(base + 257) !== {1'b0, d2, k2}) $display("FAIL b2b_frame2 got=%h", get_frame(base + 257)); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle_after busy=%b exp=0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] d = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        logic [127:0] k = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
        int base = pulses;
        bit ok;
        bit hit = 1'b0;
        fixed_dly = 1;
        start_frame(d, k, 1'b1, ok);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (pulses - base >= 101) begin
                hit = 1'b1;
                break;
            end
        end
        total++; if (!hit) $display("FAIL rst_mid_reach_bit100 pulses=%0d exp=101", pulses - base); else passed++;
        reset_b = 1'b0;
        #1;
        total++; if (tx_sync !== 1'b0) $display("FAIL rst_mid_tx_sync got=%b exp=0", tx_sync); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else passed++;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (10) @(negedge clk);
        base = pulses;
        start_frame(k, d, 1'b0, ok);
        wait_done(20000, ok);
        total++; if (!ok) $display("FAIL rst_mid_refr_timeout got=0 exp=1"); else passed++;
        repeat (3) @(negedge clk);
        total++; if (get_frame(base) !== {1'b0, k, d}) $display("FAIL rst_mid_reframe got=%h exp=%h", get_frame(base), {1'b0, k, d}); else passed++;
    endtask

`ifdef LINK_TIMEOUT_EN
    task automatic test_timeout();
        int base = pulses;
        int dbase = dones;
        bit ok;
        bit started = 1'b0;
        fixed_dly = 1;
        stop_base = base;
        peer_stop = 5;
        start_frame(128'h1, 128'h2, 1'b1, ok);
        wait_done(3000, ok);
        total++; if (!ok) $display("FAIL to_done_pulse got=0 exp=1"); else passed++;
        total++; if (error !== 1'b1) $display("FAIL to_error got=%b exp=1", error); else passed++;
        total++; if (tx_sync !== 1'b0) $display("FAIL to_tx_sync got=%b exp=0", tx_sync); else passed++;
        total++; if (txd !== 1'b0) $display("FAIL to_txd got=%b exp=0", txd); else passed++;
        total++; if (pulses - base != 6) $display("FAIL to_pulses got=%0d exp=6", pulses - base); else passed++;
        peer_stop = -1;
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) started = 1'b1;
        end
        enable = 1'b0;
        total++; if (started) $display("FAIL to_enable_ignored busy=1 exp=0"); else passed++;
        total++; if (dones - dbase != 1) $display("FAIL to_done_count got=%0d exp=1", dones - dbase); else passed++;
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        total++; if (error !== 1'b0) $display("FAIL to_error_cleared got=%b exp=0", error); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_decrypt();
        test_slow_peer();
        test_busy_peer();
        test_back_to_back();
        test_reset_mid();
`ifdef LINK_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
